frame_capture_ctrl: RTL

Capture sequencer for the video-in pixel stream. On a software capture request it waits for start-of-packet and accepts exactly one frame of 24-bit RGB beats. Each beat is packed into a 32-bit {8'h00, B, G, R} word and written to frame-buffer memory at consecutive word addresses. It reports completion and framing errors, and outside a capture it drains the stream so upstream never stalls.

---
 rtl/frame_capture_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: turns one RGB frame from a valid/ready stream into packed {0,B,G,R} word writes.
// Latency 1 cycle from accepted beat to wr_en; stream_ready drops while a write stalls and in DONE, beats are discarded when not capturing.
// `define FRAME_CAPTURE_CONT_EN for continuous double-buffered capture; the default build is single-shot.
module frame_capture_ctrl #(
    parameter int IDW       = 23,
    parameter int ODW       = 31,
    parameter int AW        = 18,
    parameter int WIDTH     = 320,
    parameter int HEIGHT    = 240,
    parameter int BUF0_BASE = 0,
    parameter int BUF1_BASE = 76800
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IDW:0]  stream_data,
    input  logic          stream_startofpacket,
    input  logic          stream_endofpacket,
    input  logic          stream_valid,
    output logic          stream_ready,
    input  logic          capture_start,
    input  logic          capture_abort,
    output logic [AW:0]   wr_addr,
    output logic [ODW:0]  wr_data,
    output logic          wr_en,
    input  logic          wr_waitrequest,
    output logic          busy,
    output logic          done,
    output logic          error_short,
    output logic          error_long,
    output logic [17:0]   pixel_count,
    output logic          front_buf
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_SOP = 3'd1;
    localparam logic [2:0] S_CAPTURE  = 3'd2;
    localparam logic [2:0] S_DRAIN    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [17:0] FRAME_PIX = 18'(WIDTH * HEIGHT);
    localparam logic [AW:0] BASE0     = (AW+1)'(BUF0_BASE);
    localparam logic [AW:0] BASE1     = (AW+1)'(BUF1_BASE);

    logic [2:0]   state;
    logic         abort_pend;
    logic         buf_sel;
    logic         stall;
    logic         accept;
    logic [17:0]  cnt_nxt;
    logic [AW:0]  base_addr;
    logic [ODW:0] packed_pix;

    assign stall      = wr_en && wr_waitrequest;
    assign accept     = stream_valid && stream_ready;
    assign busy       = (state != S_IDLE);
    assign cnt_nxt    = (pixel_count == FRAME_PIX) ? pixel_count : pixel_count + 18'd1;
    assign base_addr  = buf_sel ? BASE1 : BASE0;
    assign packed_pix = {{(ODW-IDW){1'b0}}, stream_data[7:0], stream_data[15:8], stream_data[23:16]};

    always_comb begin
        stream_ready = 1'b0;
        case (state)
            S_IDLE:              stream_ready = 1'b1;
            S_WAIT_SOP, S_DRAIN: stream_ready = !abort_pend && !capture_abort;
            S_CAPTURE:           stream_ready = !stall && !abort_pend && !capture_abort;
            default:             stream_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            abort_pend  <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            done        <= 1'b0;
            error_short <= 1'b0;
            error_long  <= 1'b0;
            pixel_count <= '0;
        end else begin
            done <= 1'b0;
            if (wr_en && !wr_waitrequest)
                wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (capture_start && !capture_abort) begin
                        error_short <= 1'b0;
                        error_long  <= 1'b0;
                        pixel_count <= '0;
                        state       <= S_WAIT_SOP;
                    end
                end
                S_WAIT_SOP, S_CAPTURE, S_DRAIN: begin
                    // An abort stalled behind a held write waits for it before leaving.
                    if (abort_pend) begin
                        if (!stall) begin
                            abort_pend <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end else if (capture_abort) begin
                        if (stall)
                            abort_pend <= 1'b1;
                        else
                            state <= S_IDLE;
                    end else if (accept) begin
                        if (state == S_DRAIN) begin
                            if (stream_endofpacket)
                                state <= S_DONE;
                        end else if (state == S_CAPTURE && stream_startofpacket) begin
                            error_short <= 1'b1;
                            state       <= S_DONE;
                        end else if (state == S_CAPTURE || stream_startofpacket) begin
                            wr_en       <= 1'b1;
                            wr_addr     <= base_addr + (AW+1)'(pixel_count);
                            wr_data     <= packed_pix;
                            pixel_count <= cnt_nxt;
                            if (stream_endofpacket) begin
                                if (cnt_nxt != FRAME_PIX)
                                    error_short <= 1'b1;
                                state <= S_DONE;
                            end else if (cnt_nxt == FRAME_PIX) begin
                                error_long <= 1'b1;
                                state      <= S_DRAIN;
                            end else begin
                                state <= S_CAPTURE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        done <= 1'b1;
`ifdef FRAME_CAPTURE_CONT_EN
                        error_short <= 1'b0;
                        error_long  <= 1'b0;
                        pixel_count <= '0;
                        state       <= S_WAIT_SOP;
`else
                        state <= S_IDLE;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FRAME_CAPTURE_CONT_EN
    // Buffer index flips on every completed frame, errored or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_sel   <= 1'b0;
            front_buf <= 1'b0;
        end else if (state == S_DONE && !stall) begin
            front_buf <= buf_sel;
            buf_sel   <= !buf_sel;
        end
    end
`else
    assign buf_sel   = 1'b0;
    assign front_buf = 1'b0;
`endif

endmodule
